// File: rtl/decode_queue.sv
// decode_queue: circular buffer between fetch and issue. Up to FETCH_WIDTH raw instructions
// enter per cycle, and up to ISSUE_WIDTH decoded instructions leave per cycle in program order.
// When KEEP_DELAY_SLOT is set, a branch/jump is only presented together with its delay slot.
//
// out_instr lane layout (decoded_instr_t, 88 bits, MSB first):
//   [87:82] op  [81:77] dest  [76:72] srca  [71:67] srcb  [66:35] imm  [34:3] target
//   [2] ctl.jump  [1] ctl.branch  [0] exception_ri
module decode_queue #(
  parameter int unsigned FETCH_WIDTH     = 2,
  parameter int unsigned ISSUE_WIDTH     = 2,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned KEEP_DELAY_SLOT = 1
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]    in_count,
  input  logic [FETCH_WIDTH-1:0][31:0]        in_instr,
  input  logic [FETCH_WIDTH-1:0][31:0]        in_pc,
  output logic [ISSUE_WIDTH-1:0]              out_valid,
  output logic [ISSUE_WIDTH-1:0][87:0]        out_instr,
  output logic [ISSUE_WIDTH-1:0][31:0]        out_pc,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]    out_accept,
  output logic [$clog2(DEPTH+1)-1:0]          count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned InW  = $clog2(FETCH_WIDTH + 1);
  localparam int unsigned AccW = $clog2(ISSUE_WIDTH + 1);
  localparam bit DsActive = (KEEP_DELAY_SLOT != 0) && (ISSUE_WIDTH > 1);

  typedef enum logic [5:0] {
    OpReserved = 6'd0,  OpAddu  = 6'd1,  OpSubu  = 6'd2,  OpAnd  = 6'd3,  OpOr   = 6'd4,
    OpXor      = 6'd5,  OpNor   = 6'd6,  OpSlt   = 6'd7,  OpSltu = 6'd8,  OpSll  = 6'd9,
    OpSrl      = 6'd10, OpSra   = 6'd11, OpJr    = 6'd12, OpAddiu = 6'd13, OpSlti = 6'd14,
    OpSltiu    = 6'd15, OpAndi  = 6'd16, OpOri   = 6'd17, OpXori = 6'd18, OpLui  = 6'd19,
    OpLw       = 6'd20, OpSw    = 6'd21, OpBeq   = 6'd22, OpBne  = 6'd23, OpJ    = 6'd24,
    OpJal      = 6'd25
  } op_e;

  typedef struct packed {
    logic jump;
    logic branch;
  } ctl_t;

  typedef struct packed {
    op_e         op;
    logic [4:0]  dest;
    logic [4:0]  srca;
    logic [4:0]  srcb;
    logic [31:0] imm;
    logic [31:0] target;
    ctl_t        ctl;
    logic        exception_ri;
  } decoded_instr_t;

  // Single-instruction decoder, one copy per issue lane.
  function automatic decoded_instr_t decode(input logic [31:0] ir, input logic [31:0] pc);
    decoded_instr_t d;
    logic [31:0]    pcplus4;
    logic [31:0]    simm;
    logic           shift;
    pcplus4 = pc + 32'd4;
    simm    = {{16{ir[15]}}, ir[15:0]};
    shift   = 1'b0;
    d       = '0;
    d.srca  = ir[25:21];
    d.srcb  = ir[20:16];
    d.dest  = ir[20:16];
    case (ir[31:26])
      6'h00: begin
        d.dest = ir[15:11];
        case (ir[5:0])
          6'h21: d.op = OpAddu;
          6'h23: d.op = OpSubu;
          6'h24: d.op = OpAnd;
          6'h25: d.op = OpOr;
          6'h26: d.op = OpXor;
          6'h27: d.op = OpNor;
          6'h2a: d.op = OpSlt;
          6'h2b: d.op = OpSltu;
          6'h00: begin d.op = OpSll; shift = 1'b1; end
          6'h02: begin d.op = OpSrl; shift = 1'b1; end
          6'h03: begin d.op = OpSra; shift = 1'b1; end
          6'h08: begin
            d.op       = OpJr;
            d.ctl.jump = 1'b1;
            d.srcb     = '0;
            d.dest     = '0;
          end
          default: d.exception_ri = 1'b1;
        endcase
        if (shift) begin
          d.srca = '0;
          d.imm  = {27'd0, ir[10:6]};
        end
      end
      6'h02, 6'h03: begin
        d.op       = ir[26] ? OpJal : OpJ;
        d.ctl.jump = 1'b1;
        d.srca     = '0;
        d.srcb     = '0;
        d.dest     = ir[26] ? 5'd31 : 5'd0;
        d.target   = {pcplus4[31:28], ir[25:0], 2'b00};
      end
      6'h04, 6'h05: begin
        d.op         = ir[26] ? OpBne : OpBeq;
        d.ctl.branch = 1'b1;
        d.dest       = '0;
        d.imm        = simm;
        d.target     = pcplus4 + {simm[29:0], 2'b00};
      end
      6'h09: begin d.op = OpAddiu; d.srcb = '0; d.imm = simm; end
      6'h0a: begin d.op = OpSlti;  d.srcb = '0; d.imm = simm; end
      6'h0b: begin d.op = OpSltiu; d.srcb = '0; d.imm = simm; end
      6'h0c: begin d.op = OpAndi;  d.srcb = '0; d.imm = {16'd0, ir[15:0]}; end
      6'h0d: begin d.op = OpOri;   d.srcb = '0; d.imm = {16'd0, ir[15:0]}; end
      6'h0e: begin d.op = OpXori;  d.srcb = '0; d.imm = {16'd0, ir[15:0]}; end
      6'h0f: begin
        d.op   = OpLui;
        d.srca = '0;
        d.srcb = '0;
        d.imm  = {ir[15:0], 16'd0};
      end
      6'h23: begin d.op = OpLw; d.srcb = '0; d.imm = simm; end
      6'h2b: begin d.op = OpSw; d.dest = '0; d.imm = simm; end
      default: d.exception_ri = 1'b1;
    endcase
    // Reserved encodings still issue, but carry no operands.
    if (d.exception_ri) begin
      d              = '0;
      d.exception_ri = 1'b1;
    end
    return d;
  endfunction

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic                   push;
  logic [InW-1:0]         push_cnt;
  logic [FETCH_WIDTH-1:0] wr_en;
  logic [ISSUE_WIDTH-1:0] lane_cti;
  decoded_instr_t         lane_dec [ISSUE_WIDTH];

  // Readiness looks only at current occupancy, never at this cycle's pop.
  assign in_ready = count_q <= CntW'(DEPTH - FETCH_WIDTH);
  assign push     = in_valid && in_ready && !flush;
  assign push_cnt = push ? in_count : '0;
  assign count    = count_q;

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_wr
    assign wr_en[g] = push && (in_count > InW'(g));
  end

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_lane
    logic [PtrW-1:0] rd_idx;
    assign rd_idx       = head_q + PtrW'(g);
    assign lane_dec[g]  = decode(instr_mem[rd_idx], pc_mem[rd_idx]);
    assign lane_cti[g]  = lane_dec[g].ctl.jump | lane_dec[g].ctl.branch;
    assign out_instr[g] = lane_dec[g];
    assign out_pc[g]    = pc_mem[rd_idx];
  end

  // Valid lanes form a prefix; a control-transfer lane also needs its delay slot present.
  always_comb begin
    logic chain;
    out_valid = '0;
    chain     = 1'b1;
    for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
      chain = chain && (count_q > CntW'(i));
      if (DsActive && chain && lane_cti[i]) begin
        chain = (i + 1 < int'(ISSUE_WIDTH)) && (count_q > CntW'(i + 1));
      end
      out_valid[i] = chain;
    end
  end

  // Pointer/occupancy update; flush wins over this cycle's push and pop.
  always_comb begin
    head_d  = head_q + PtrW'(out_accept);
    tail_d  = tail_q + PtrW'(push_cnt);
    count_d = count_q + CntW'(push_cnt) - CntW'(out_accept);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Queue state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written in lane order starting at tail; not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(FETCH_WIDTH); k++) begin
      if (wr_en[k]) begin
        instr_mem[tail_q + PtrW'(k)] <= in_instr[k];
        pc_mem[tail_q + PtrW'(k)]    <= in_pc[k];
      end
    end
  end

`ifndef SYNTHESIS
  a_in_count: assert property (@(posedge clk) disable iff (!resetn)
    in_valid |-> in_count <= InW'(FETCH_WIDTH));

  a_accept: assert property (@(posedge clk) disable iff (!resetn)
    !flush |-> int'(out_accept) <= $countones(out_valid));

  if (DsActive) begin : g_pair_chk
    for (genvar g = 0; g < ISSUE_WIDTH - 1; g++) begin : g_lane_chk
      a_pair: assert property (@(posedge clk) disable iff (!resetn)
        (!flush && out_valid[g] && lane_cti[g]) |->
          (out_accept <= AccW'(g)) || (out_accept > AccW'(g + 1)));
    end
  end
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: a queue-level model checked every cycle, plus directed literal checks.
module tb_decode_queue;

  localparam int FW = 2;
  localparam int IW = 2;
  localparam int DEPTH = 8;

  // Decoded op numbers.
  localparam int OP_RES = 0, OP_ADDU = 1, OP_SUBU = 2, OP_AND = 3, OP_OR = 4, OP_XOR = 5;
  localparam int OP_NOR = 6, OP_SLT = 7, OP_SLTU = 8, OP_SLL = 9, OP_SRL = 10, OP_SRA = 11;
  localparam int OP_JR = 12, OP_ADDIU = 13, OP_SLTI = 14, OP_SLTIU = 15, OP_ANDI = 16;
  localparam int OP_ORI = 17, OP_XORI = 18, OP_LUI = 19, OP_LW = 20, OP_SW = 21;
  localparam int OP_BEQ = 22, OP_BNE = 23, OP_J = 24, OP_JAL = 25;

  // Operand formats used by the reference decoder.
  localparam int FmtRi = 0, FmtR = 1, FmtSh = 2, FmtJr = 3, FmtJ = 4, FmtB = 5;
  localparam int FmtIs = 6, FmtIz = 7, FmtLui = 8, FmtSw = 9;

  logic             clk = 1'b0;
  logic             resetn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_count;
  logic [1:0][31:0] in_instr;
  logic [1:0][31:0] in_pc;
  logic [1:0]       out_valid;
  logic [1:0][87:0] out_instr;
  logic [1:0][31:0] out_pc;
  logic [1:0]       out_accept;
  logic [3:0]       count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t mq[$];
  int     checks = 0;
  int     errors = 0;
  bit     check_en = 1'b0;

  decode_queue #(
    .FETCH_WIDTH    (FW),
    .ISSUE_WIDTH    (IW),
    .DEPTH          (DEPTH),
    .KEEP_DELAY_SLOT(1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_accept(out_accept),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode: classify op and operand format, then fill fields from the format.
  function automatic logic [87:0] ref_decode(input logic [31:0] ir, input logic [31:0] pc);
    int op, fmt;
    logic [4:0]  dst, sa, sb;
    logic [31:0] imm, tgt, se, npc;
    logic        j, b, ri;
    op  = OP_RES;
    fmt = FmtRi;
    se  = {{16{ir[15]}}, ir[15:0]};
    npc = pc + 32'd4;
    if (ir[31:26] == 6'h00) begin
      case (ir[5:0])
        6'h21: begin op = OP_ADDU; fmt = FmtR; end
        6'h23: begin op = OP_SUBU; fmt = FmtR; end
        6'h24: begin op = OP_AND;  fmt = FmtR; end
        6'h25: begin op = OP_OR;   fmt = FmtR; end
        6'h26: begin op = OP_XOR;  fmt = FmtR; end
        6'h27: begin op = OP_NOR;  fmt = FmtR; end
        6'h2a: begin op = OP_SLT;  fmt = FmtR; end
        6'h2b: begin op = OP_SLTU; fmt = FmtR; end
        6'h00: begin op = OP_SLL;  fmt = FmtSh; end
        6'h02: begin op = OP_SRL;  fmt = FmtSh; end
        6'h03: begin op = OP_SRA;  fmt = FmtSh; end
        6'h08: begin op = OP_JR;   fmt = FmtJr; end
        default: ;
      endcase
    end else begin
      case (ir[31:26])
        6'h02: begin op = OP_J;     fmt = FmtJ; end
        6'h03: begin op = OP_JAL;   fmt = FmtJ; end
        6'h04: begin op = OP_BEQ;   fmt = FmtB; end
        6'h05: begin op = OP_BNE;   fmt = FmtB; end
        6'h09: begin op = OP_ADDIU; fmt = FmtIs; end
        6'h0a: begin op = OP_SLTI;  fmt = FmtIs; end
        6'h0b: begin op = OP_SLTIU; fmt = FmtIs; end
        6'h0c: begin op = OP_ANDI;  fmt = FmtIz; end
        6'h0d: begin op = OP_ORI;   fmt = FmtIz; end
        6'h0e: begin op = OP_XORI;  fmt = FmtIz; end
        6'h0f: begin op = OP_LUI;   fmt = FmtLui; end
        6'h23: begin op = OP_LW;    fmt = FmtIs; end
        6'h2b: begin op = OP_SW;    fmt = FmtSw; end
        default: ;
      endcase
    end
    dst = '0; sa = '0; sb = '0; imm = '0; tgt = '0; j = 1'b0; b = 1'b0; ri = 1'b0;
    case (fmt)
      FmtR:   begin dst = ir[15:11]; sa = ir[25:21]; sb = ir[20:16]; end
      FmtSh:  begin dst = ir[15:11]; sb = ir[20:16]; imm = 32'(ir[10:6]); end
      FmtJr:  begin sa = ir[25:21]; j = 1'b1; end
      FmtJ:   begin
        j   = 1'b1;
        tgt = {npc[31:28], ir[25:0], 2'b00};
        if (op == OP_JAL) dst = 5'd31;
      end
      FmtB:   begin sa = ir[25:21]; sb = ir[20:16]; imm = se; b = 1'b1; tgt = npc + (se << 2); end
      FmtIs:  begin dst = ir[20:16]; sa = ir[25:21]; imm = se; end
      FmtIz:  begin dst = ir[20:16]; sa = ir[25:21]; imm = {16'd0, ir[15:0]}; end
      FmtLui: begin dst = ir[20:16]; imm = {ir[15:0], 16'd0}; end
      FmtSw:  begin sa = ir[25:21]; sb = ir[20:16]; imm = se; end
      default: ri = 1'b1;
    endcase
    return {6'(op), dst, sa, sb, imm, tgt, j, b, ri};
  endfunction

  function automatic bit is_cti(input logic [31:0] ir);
    logic [87:0] d;
    d = ref_decode(ir, 32'd0);
    return d[2] | d[1];
  endfunction

  // Lanes issue in order while entries exist; a branch needs the next entry in the next lane.
  function automatic logic [1:0] model_valid();
    logic [1:0] v;
    v = '0;
    for (int i = 0; i < IW; i++) begin
      if (i >= mq.size()) break;
      if (is_cti(mq[i].instr) && !((i + 1 < IW) && (mq.size() > i + 1))) break;
      v[i] = 1'b1;
    end
    return v;
  endfunction

  // Per-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      logic [1:0] ev;
      ev = model_valid();
      chk("count", 128'(count), 128'(mq.size()));
      chk("in_ready", 128'(in_ready), 128'((DEPTH - mq.size()) >= FW));
      chk("out_valid", 128'(out_valid), 128'(ev));
      for (int i = 0; i < IW; i++) begin
        if (ev[i]) begin
          chk($sformatf("out_pc[%0d]", i), 128'(out_pc[i]), 128'(mq[i].pc));
          chk($sformatf("out_instr[%0d]", i), 128'(out_instr[i]),
              128'(ref_decode(mq[i].instr, mq[i].pc)));
        end
      end
    end
  end

  task automatic idle();
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_count   = 2'd0;
    out_accept = 2'd0;
  endtask

  // One clock of stimulus; the model advances with the same inputs, then inputs go idle.
  task automatic step(input bit fl, input bit iv, input int ic, input logic [31:0] i0,
                      input logic [31:0] p0, input logic [31:0] i1, input logic [31:0] p1,
                      input int acc);
    bit rdy;
    @(negedge clk);
    #1;
    flush       = fl;
    in_valid    = iv;
    in_count    = 2'(ic);
    in_instr[0] = i0;
    in_pc[0]    = p0;
    in_instr[1] = i1;
    in_pc[1]    = p1;
    out_accept  = 2'(acc);
    if (fl) begin
      mq.delete();
    end else begin
      rdy = (DEPTH - mq.size()) >= FW;
      for (int k = 0; k < acc; k++) void'(mq.pop_front());
      if (iv && rdy) begin
        if (ic > 0) mq.push_back('{instr: i0, pc: p0});
        if (ic > 1) mq.push_back('{instr: i1, pc: p1});
      end
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic logic [31:0] rand_alu();
    logic [4:0] rs, rt, rd;
    rs = 5'($urandom);
    rt = 5'($urandom);
    rd = 5'($urandom);
    case ($urandom_range(0, 5))
      0: return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      1: return {6'h00, rs, rt, rd, 5'd0, 6'h2a};
      2: return {6'h09, rs, rt, 16'($urandom)};
      3: return {6'h0d, rs, rt, 16'($urandom)};
      4: return {6'h0f, 5'd0, rt, 16'($urandom)};
      default: return {6'h0e, rs, rt, 16'($urandom)};
    endcase
  endfunction

  initial begin
    logic [31:0] push_pc, next_pc;
    resetn   = 1'b0;
    in_instr = '0;
    in_pc    = '0;
    idle();
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b1;
    chk("reset count", 128'(count), 128'(0));
    chk("reset out_valid", 128'(out_valid), 128'(2'b00));
    chk("reset in_ready", 128'(in_ready), 128'(1));
    check_en = 1'b1;

    // Basic two-lane decode.
    step(0, 1, 2, 32'h24010005, 32'hBFC00000, 32'h34220F0F, 32'hBFC00004, 0);
    chk("basic valid", 128'(out_valid), 128'(2'b11));
    chk("lane0 op", 128'(out_instr[0][87:82]), 128'(OP_ADDIU));
    chk("lane0 imm", 128'(out_instr[0][66:35]), 128'(32'd5));
    chk("lane0 dest", 128'(out_instr[0][81:77]), 128'(1));
    chk("lane1 op", 128'(out_instr[1][87:82]), 128'(OP_ORI));
    chk("lane1 imm", 128'(out_instr[1][66:35]), 128'(32'h00000F0F));
    chk("lane1 srca", 128'(out_instr[1][76:72]), 128'(1));
    chk("lane1 dest", 128'(out_instr[1][81:77]), 128'(2));
    step(0, 0, 0, 0, 0, 0, 0, 2);

    // Branch waits for its delay slot.
    step(0, 1, 1, 32'h10220003, 32'hBFC00010, 0, 0, 0);
    chk("lone branch valid", 128'(out_valid), 128'(2'b00));
    chk("lone branch count", 128'(count), 128'(1));
    step(0, 1, 1, 32'h00000000, 32'hBFC00014, 0, 0, 0);
    chk("paired valid", 128'(out_valid), 128'(2'b11));
    chk("branch imm", 128'(out_instr[0][66:35]), 128'(32'd3));
    chk("branch target", 128'(out_instr[0][34:3]), 128'(32'hBFC00020));
    chk("branch ctl", 128'(out_instr[0][1]), 128'(1));
    step(0, 0, 0, 0, 0, 0, 0, 2);
    step(0, 1, 2, 32'h00221821, 32'hBFC00020, 32'h10220003, 32'hBFC00024, 0);
    chk("branch in lane1 valid", 128'(out_valid), 128'(2'b01));
    step(0, 1, 1, 32'h00000000, 32'hBFC00028, 0, 0, 1);
    chk("branch moved to lane0", 128'(out_valid), 128'(2'b11));
    chk("branch lane0 pc", 128'(out_pc[0]), 128'(32'hBFC00024));
    step(0, 0, 0, 0, 0, 0, 0, 2);

    // in_count of zero pushes nothing.
    step(0, 1, 0, 32'h24010001, 32'hBFC00030, 0, 0, 0);
    chk("zero push count", 128'(count), 128'(0));

    // Fill to full under backpressure.
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 2, 32'h24020000 + 32'(k), 32'hBFC00100 + 32'(8 * k),
           32'h24030000 + 32'(k), 32'hBFC00104 + 32'(8 * k), 0);
    end
    chk("full count", 128'(count), 128'(8));
    chk("full in_ready", 128'(in_ready), 128'(0));
    step(0, 1, 2, 32'h24040000, 32'hBFC00180, 32'h24050000, 32'hBFC00184, 0);
    chk("push while full", 128'(count), 128'(8));
    step(0, 0, 0, 0, 0, 0, 0, 2);
    chk("after pop count", 128'(count), 128'(6));
    chk("after pop in_ready", 128'(in_ready), 128'(1));
    step(0, 1, 1, 32'h24060000, 32'hBFC00190, 0, 0, 0);
    chk("count7", 128'(count), 128'(7));
    chk("count7 in_ready", 128'(in_ready), 128'(0));
    step(0, 0, 0, 0, 0, 0, 0, 2);
    chk("count5", 128'(count), 128'(5));

    // Flush beats a simultaneous push and accept.
    step(1, 1, 2, 32'h2407DEAD, 32'hDEAD0000, 32'h2408BEEF, 32'hDEAD0004, 2);
    chk("flush count", 128'(count), 128'(0));
    chk("flush out_valid", 128'(out_valid), 128'(2'b00));

    // Reserved encoding issues flagged.
    step(0, 1, 1, 32'hFC000000, 32'hBFC00200, 0, 0, 0);
    chk("ri valid", 128'(out_valid), 128'(2'b01));
    chk("ri pc", 128'(out_pc[0]), 128'(32'hBFC00200));
    chk("ri flag", 128'(out_instr[0][0]), 128'(1));
    chk("ri op", 128'(out_instr[0][87:82]), 128'(OP_RES));
    chk("ri srca", 128'(out_instr[0][76:72]), 128'(0));
    chk("ri srcb", 128'(out_instr[0][71:67]), 128'(0));
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Streaming across pointer wrap.
    push_pc = 32'h80000000;
    next_pc = 32'h80000000;
    step(0, 1, 2, rand_alu(), push_pc, rand_alu(), push_pc + 32'd4, 0);
    push_pc = push_pc + 32'd8;
    for (int c = 0; c < 40; c++) begin
      chk("stream count", 128'(count), 128'(2));
      chk("stream pc0", 128'(out_pc[0]), 128'(next_pc));
      chk("stream pc1", 128'(out_pc[1]), 128'(next_pc + 32'd4));
      step(0, 1, 2, rand_alu(), push_pc, rand_alu(), push_pc + 32'd4, 2);
      push_pc = push_pc + 32'd8;
      next_pc = next_pc + 32'd8;
    end
    step(0, 0, 0, 0, 0, 0, 0, 2);
    chk("drained", 128'(count), 128'(0));

    // Asynchronous reset in the middle of traffic.
    step(0, 1, 2, 32'h24090001, 32'hBFC00300, 32'h240A0002, 32'hBFC00304, 0);
    #2;
    resetn = 1'b0;
    mq.delete();
    #1;
    chk("async reset count", 128'(count), 128'(0));
    chk("async reset valid", 128'(out_valid), 128'(2'b00));
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
    step(0, 1, 2, 32'h240B0003, 32'hBFC00400, 32'h240C0004, 32'hBFC00404, 0);
    chk("post reset count", 128'(count), 128'(2));
    chk("post reset pc0", 128'(out_pc[0]), 128'(32'hBFC00400));

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
Multi-lane decode buffer between fetch and issue in the mycpu pipeline. It accepts up to FETCH_WIDTH raw instructions per cycle into a circular queue of DEPTH entries. It presents up to ISSUE_WIDTH in-order decoded instructions (decoded_instr_t) per cycle, with one existing single-instruction decoder instance per issue lane. It also enforces branch/delay-slot pairing and supports a pipeline flush.

Parameters:
FETCH_WIDTH, 2, max instructions pushed per cycle (>=1)
ISSUE_WIDTH, 2, decoded output lanes (>=1)
DEPTH, 8, queue entries; power of 2, >= FETCH_WIDTH+ISSUE_WIDTH
KEEP_DELAY_SLOT, 1, 1 = a branch/jump issues only in the same cycle as its delay slot

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
flush  input  1  synchronous queue clear (redirect/exception)
in_valid  input  1  fetch group valid
in_ready  output  1  queue can take a full fetch group this cycle
in_count  input  $clog2(FETCH_WIDTH+1)  number of valid slots in group, lanes 0..in_count-1
in_instr  input  FETCH_WIDTH x 32  raw instructions, lane 0 oldest
in_pc  input  FETCH_WIDTH x 32  PC per slot
out_valid  output  ISSUE_WIDTH  per-lane valid; always a contiguous prefix from lane 0
out_instr  output  ISSUE_WIDTH x decoded_instr_t  decoded instruction per lane
out_pc  output  ISSUE_WIDTH x 32  PC per lane
out_accept  input  $clog2(ISSUE_WIDTH+1)  lanes consumed this cycle, prefix from lane 0
count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (resetn=0, async): head=tail=0, count=0; out_valid=0, in_ready=1; entry storage is not reset.
- Storage per entry: raw instr (32b) + pc (32b). Decode is combinational on read. pcplus4 = pc+4 mod 2^32 feeds the jump-target field.
- in_ready = (DEPTH-count) >= FETCH_WIDTH, computed from current count only (not pending pop).
- Push: when in_valid&in_ready&!flush, write in_count entries at tail in lane order; tail += in_count mod DEPTH. in_count=0 is a no-op. in_count>FETCH_WIDTH is illegal (assertion).
- Lane i reads entry (head+i) mod DEPTH. Base valid: count > i, and all lanes <i valid.
- Delay-slot rule (KEEP_DELAY_SLOT=1 and ISSUE_WIDTH>1): if lane i decodes with ctl.jump|ctl.branch, it is valid only if i+1<ISSUE_WIDTH and count>i+1. Otherwise lane i and all later lanes are 0. A branch in the last lane therefore waits and moves to lane 0 next cycle. With ISSUE_WIDTH=1 or KEEP_DELAY_SLOT=0, the rule is disabled.
- Pop: head += out_accept mod DEPTH. out_accept > popcount(out_valid) is illegal. Accepting a branch lane without its delay-slot lane is illegal when the rule is active (assertion).
- Simultaneous push/pop: count_next = count + pushed - popped, same cycle. Pointers wrap modulo DEPTH using $clog2(DEPTH)-bit arithmetic.
- Flush: highest priority. Next cycle head=tail=count=0 and out_valid=0; that cycle's push and out_accept are ignored. Flush during reset has no effect.
- Reserved/illegal encodings are not filtered: they issue with exception_ri=1, op=RESERVED, srca=srcb=0.
- No output registers: out_* are combinational from queue state, so decode latency is push-to-out_valid = 1 cycle.

Test Plan:
- Reset: hold resetn=0 3 cycles, release -> count=0, out_valid=2'b00, in_ready=1; async assert mid-traffic clears count within the same cycle.
- Basic decode: push {0x24010005 @0xBFC00000, 0x34220F0F @0xBFC00004}, in_count=2 -> next cycle out_valid=2'b11. Lane0: op=ADDIU, imm=5, dest=1. Lane1: op=ORI, imm=0x00000F0F, srca=1, dest=2.
- Delay slot: push BEQ 0x10220003 @0xBFC00010 alone -> out_valid=0. Push 0x00000000 @0xBFC00014 -> out_valid=2'b11, lane0 imm=0x00000003. Branch in lane1 behind an ADDU -> out_valid=2'b01 only.
- Full/backpressure: out_accept=0, push 2/cycle -> count=8 after 4 pushes, in_ready=0 at count 7 and 8. Accept 2 -> count=6, in_ready=1.
- Wrap/streaming: 40 cycles of push 2 + accept 2 with a random ALU op stream -> count constant, PCs issued strictly in order across pointer wrap, no drop or duplicate.
- Flush + illegal: with count=5 and in_valid=1, assert flush -> count=0 next cycle, pushed group absent. Push 0xFC000000 -> lane0 exception_ri=1, op=RESERVED.
